corner_nms_picker: RTL and testbench

- Downstream of the Harris/Shi-Tomasi corner-response stage. Consumes the raster stream of 8-bit unsigned corner scores (clamped acSbb), one score per enabled pixel, tagged with the pixel coordinator's X/Y.
- Applies a threshold and 3x3 non-maximum suppression, and emits (x, y, score) keypoint records into a small FIFO. The SPI readout path drains that FIFO with a valid/ready handshake.

---
 rtl/corner_pkg.sv | 29 ++
 rtl/kp_fifo.sv | 47 ++++
 rtl/corner_nms_picker.sv | 147 ++++++++++++++
 tb/tb_corner_nms_picker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corner_pkg.sv
// Shared widths and keypoint record layout for the corner NMS picker and the SPI readout mux.
package corner_pkg;

    localparam int COORD_W  = 11;
    localparam int SCORE_W  = 8;
    localparam int KP_REC_W = 2 * COORD_W + SCORE_W;

    // Bit offsets of the record fields; x occupies the MSBs.
    localparam int KP_SCORE_LSB = 0;
    localparam int KP_Y_LSB     = SCORE_W;
    localparam int KP_X_LSB     = SCORE_W + COORD_W;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
    } kp_rec_t;

    function automatic kp_rec_t kp_pack(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [SCORE_W-1:0] score);
        kp_rec_t rec;
        rec.x     = x;
        rec.y     = y;
        rec.score = score;
        return rec;
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head data is zero while empty.
module kp_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // The extra pointer bit separates full (wrap bits differ) from empty.
    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign dout    = valid ? mem[rd_ptr[AW-1:0]] : {WIDTH{1'b0}};

    // Read/write pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {(AW+1){1'b0}};
            rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/corner_nms_picker.sv
// Thresholds the corner-score raster, applies 3x3 non-maximum suppression and queues
// (x, y, score) keypoint records for the readout path.
module corner_nms_picker
    import corner_pkg::*;
#(
    parameter int FRAME_W    = 640,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                in_en,
    input  logic [COORD_W-1:0]  in_x,
    input  logic [COORD_W-1:0]  in_y,
    input  logic [SCORE_W-1:0]  in_score,
    input  logic [SCORE_W-1:0]  thr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [KP_REC_W-1:0] out_data,
    output logic [9:0]          kp_count,
    output logic [7:0]          drop_count
);

    localparam int LB_AW = $clog2(FRAME_W);

    logic [SCORE_W-1:0] lb0 [FRAME_W];
    logic [SCORE_W-1:0] lb1 [FRAME_W];
    logic [LB_AW-1:0]   lb_idx;
    logic [SCORE_W-1:0] lb0_rd;
    logic [SCORE_W-1:0] lb1_rd;

    logic [SCORE_W-1:0] w [3][3];
    logic               armed;
    logic               cand_v;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic [SCORE_W-1:0] centre;
    logic               keypoint;
    logic               kp_r;
    kp_rec_t            rec_r;
    logic               fifo_full;
    logic               drop;

    assign lb_idx = in_x[LB_AW-1:0];
    assign lb0_rd = lb0[lb_idx];
    assign lb1_rd = lb1[lb_idx];

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    always_ff @(posedge clk) begin
        if (in_en) begin
            lb1[lb_idx] <= lb0_rd;
            lb0[lb_idx] <= in_score;
        end
    end

    // 3x3 window shifts left one column per pixel; new column enters on the right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= {SCORE_W{1'b0}};
                end
            end
        end else if (in_en) begin
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= w[r][1];
                w[r][1] <= w[r][2];
            end
            w[0][2] <= lb1_rd;
            w[1][2] <= lb0_rd;
            w[2][2] <= in_score;
        end
    end

    // Candidate centre tracking; a candidate lives for exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed  <= 1'b0;
            cand_v <= 1'b0;
            cand_x <= {COORD_W{1'b0}};
            cand_y <= {COORD_W{1'b0}};
        end else begin
            if (frame_start) armed <= 1'b1;
            if (frame_start) begin
                cand_v <= 1'b0;
            end else if (in_en) begin
                cand_v <= armed && (in_x >= COORD_W'(2)) && (in_y >= COORD_W'(2));
            end else begin
                cand_v <= 1'b0;
            end
            if (in_en) begin
                cand_x <= in_x - COORD_W'(1);
                cand_y <= in_y - COORD_W'(1);
            end
        end
    end

    // Strict against raster-earlier neighbours, non-strict against later ones:
    // a flat plateau yields only its first pixel in raster order.
    assign centre   = w[1][1];
    assign keypoint = cand_v && (centre >= thr)
                   && (centre >  w[0][0]) && (centre >  w[0][1]) && (centre >  w[0][2])
                   && (centre >  w[1][0]) && (centre >= w[1][2])
                   && (centre >= w[2][0]) && (centre >= w[2][1]) && (centre >= w[2][2]);

    // Decision is captured before the window shifts again, then pushed next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_r  <= 1'b0;
            rec_r <= kp_pack({COORD_W{1'b0}}, {COORD_W{1'b0}}, {SCORE_W{1'b0}});
        end else begin
            kp_r  <= keypoint;
            rec_r <= kp_pack(cand_x, cand_y, centre);
        end
    end

    kp_fifo #(
        .WIDTH (KP_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kp_r),
        .din   (rec_r),
        .pop   (out_ready),
        .dout  (out_data),
        .valid (out_valid),
        .full  (fifo_full)
    );

    assign drop = kp_r & fifo_full & ~(out_valid & out_ready);

    // Per-frame saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_count   <= 10'd0;
            drop_count <= 8'd0;
        end else if (frame_start) begin
            kp_count   <= 10'd0;
            drop_count <= 8'd0;
        end else begin
            if (kp_r && (kp_count != 10'h3FF))  kp_count   <= kp_count + 10'd1;
            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_corner_nms_picker.sv
// Self-checking bench: directed scenarios plus random frames against a frame-array NMS model.
module tb_corner_nms_picker;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        in_en;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic [7:0]  in_score;
    logic [7:0]  thr;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [9:0]  kp_count;
    logic [7:0]  drop_count;

    corner_nms_picker #(.FRAME_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_en       (in_en),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_score    (in_score),
        .thr         (thr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .kp_count    (kp_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          img [H][W];
    int          sc  [H][W];
    bit          armed_m;
    bit          p1_v, p2_v;
    logic [29:0] p1_rec, p2_rec;
    logic [29:0] q [$];
    int          kp_m, drop_m;
    int          ready_mode;
    int          cyc;
    int          feed_cyc;
    int          rise_cyc;
    logic [29:0] rise_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // NMS rule from the frame array: strict vs raster-earlier, non-strict vs later neighbours
    function automatic bit model_kp(int cx, int cy);
        int c = sc[cy][cx];
        if (c < int'(thr)) return 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int n = sc[cy+dy][cx+dx];
                if (dy == 0 && dx == 0) continue;
                if ((dy < 0) || (dy == 0 && dx < 0)) begin
                    if (!(c > n)) return 1'b0;
                end else begin
                    if (!(c >= n)) return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        kp_m = 0; drop_m = 0; armed_m = 1'b0; p1_v = 1'b0; p2_v = 1'b0;
    endtask

    task automatic model_step();
        logic [10:0] cx, cy;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (p2_v) begin
            if (kp_m < 1023) kp_m++;
            if (q.size() < DEPTH) q.push_back(p2_rec);
            else if (drop_m < 255) drop_m++;
        end
        if (frame_start) begin kp_m = 0; drop_m = 0; end
        p2_v = p1_v; p2_rec = p1_rec; p1_v = 1'b0;
        if (in_en) begin
            sc[in_y][in_x] = int'(in_score);
            if (armed_m && !frame_start && in_x >= 11'd2 && in_y >= 11'd2 &&
                model_kp(int'(in_x) - 1, int'(in_y) - 1)) begin
                cx = in_x - 11'd1;
                cy = in_y - 11'd1;
                p1_v = 1'b1;
                p1_rec = {cx, cy, 8'(sc[cy][cx])};
            end
        end
        if (frame_start) armed_m = 1'b1;
    endtask

    task automatic cycle();
        case (ready_mode)
            0:       out_ready = 1'b0;
            2:       out_ready = 1'($urandom % 2);
            3:       out_ready = p2_v && (q.size() == DEPTH);
            default: out_ready = 1'b1;
        endcase
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        cyc++;
        check_val("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) check_val("out_data", out_data, q[0]);
        check_val("kp_count", kp_count, kp_m);
        check_val("drop_count", drop_count, drop_m);
        if (out_valid && rise_cyc < 0) begin
            rise_cyc  = cyc;
            rise_data = out_data;
        end
    endtask

    task automatic idle(input int n);
        in_en = 1'b0; frame_start = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_frame(input bit do_fs, input int rst_row, input bit gaps);
        if (do_fs) begin
            frame_start = 1'b1; in_en = 1'b0;
            rise_cyc = -1;
            cycle();
            frame_start = 1'b0;
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == rst_row && x == 0) begin
                    in_en = 1'b0; rst = 1'b1;
                    model_reset();
                    cycle();
                    rst = 1'b0;
                end
                in_en = 1'b1; in_x = 11'(x); in_y = 11'(y); in_score = 8'(img[y][x]);
                cycle();
                if (x == 4 && y == 3) feed_cyc = cyc;
                in_en = 1'b0;
                if (gaps && ($urandom % 3 == 0)) cycle();
            end
        end
        in_en = 1'b0;
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; in_en = 1'b0; in_x = 11'd0; in_y = 11'd0;
        in_score = 8'd0; thr = 8'd10; out_ready = 1'b0; ready_mode = 1;
        cyc = 0; feed_cyc = 0; rise_cyc = -1; rise_data = 30'd0;
        model_reset();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) sc[y][x] = 0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_data", out_data, 30'd0);
        check_val("rst_kp", kp_count, 10'd0);
        check_val("rst_drop", drop_count, 8'd0);
        rst = 1'b0;
        idle(2);

        // single peak: latency and record contents
        clear_img(); img[2][3] = 50;
        send_frame(1'b1, -1, 1'b0);
        idle(6);
        check_val("peak_latency", 32'(rise_cyc - feed_cyc), 32'd2);
        check_val("peak_rec", rise_data, {11'd3, 11'd2, 8'd50});
        check_val("peak_kp", kp_count, 10'd1);

        // plateau tie: first pixel in raster order wins
        clear_img(); img[2][2] = 30; img[2][3] = 30;
        send_frame(1'b1, -1, 1'b1);
        idle(6);
        check_val("plateau_rec", rise_data, {11'd2, 11'd2, 8'd30});
        check_val("plateau_kp", kp_count, 10'd1);

        // below threshold and border pixels
        clear_img(); img[3][4] = 9; img[2][0] = 200; img[4][7] = 200;
        send_frame(1'b1, -1, 1'b0);
        idle(6);
        check_val("border_kp", kp_count, 10'd0);
        check_val("border_none", 32'(rise_cyc), 32'hFFFF_FFFF);

        // overflow with consumer stalled, then drain in order
        clear_img();
        img[1][1] = 40; img[1][4] = 40; img[1][6] = 40;
        img[3][1] = 40; img[3][4] = 40; img[3][6] = 40;
        ready_mode = 0;
        send_frame(1'b1, -1, 1'b0);
        idle(4);
        check_val("ovf_drop", drop_count, 8'd2);
        check_val("ovf_kp", kp_count, 10'd6);
        ready_mode = 1;
        idle(8);

        // full FIFO with pop in the same cycle as the push
        ready_mode = 3;
        send_frame(1'b1, -1, 1'b0);
        idle(4);
        check_val("fullpop_drop", drop_count, 8'd0);
        check_val("fullpop_kp", kp_count, 10'd6);
        ready_mode = 1;
        idle(8);

        // reset mid-frame, stream continues unarmed, then a clean frame
        clear_img(); img[2][5] = 70; img[4][3] = 90;
        send_frame(1'b1, 3, 1'b0);
        idle(6);
        check_val("rstmid_kp", kp_count, 10'd0);
        check_val("rstmid_none", out_valid, 1'b0);
        send_frame(1'b1, -1, 1'b0);
        idle(6);
        check_val("clean_kp", kp_count, 10'd2);

        // random frames against the model
        for (int f = 0; f < 8; f++) begin
            thr = 8'($urandom_range(0, 60));
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    int r = int'($urandom % 8);
                    if (r < 5)                img[y][x] = int'($urandom % 12);
                    else if (r < 7 || x == 0) img[y][x] = int'($urandom % 256);
                    else                      img[y][x] = img[y][x-1];
                end
            end
            ready_mode = 2;
            send_frame(1'b1, -1, 1'b1);
            ready_mode = 1;
            idle(8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
